// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit interval timer and interrupt source on the cpu bus.
//   Parameters: BASE (8-byte aligned window base), PRESCALE (1..256 cpu clocks per tick).
//   Ports:
//     clk  - cpu clock
//     RST  - synchronous reset, active-high
//     AD   - cpu address (combinational, valid in the current cycle)
//     DO   - cpu write data
//     WE   - cpu write enable
//     RDY  - cpu ready; an access commits only when high
//     DI   - registered read data, 0 when not selected (OR-muxed with other slaves)
//     IRQ  - registered interrupt request, IF & IE delayed one cycle
module bus_timer #(
   parameter logic [15:0] BASE     = 16'hFE00,
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] AD,
   input  logic [7:0]  DO,
   input  logic        WE,
   input  logic        RDY,
   output logic [7:0]  DI,
   output logic        IRQ
);
   localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
   logic [15:0] cnt_q, cnt_d, lat_q, lat_d;
   logic [7:0]  snap_q, snap_d, scr_q, scr_d, pre_q, pre_d, di_q, di_d, rdata;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        if_q, if_d, irq_q, irq_d;
   logic        sel, wr, rd, tick, uf;
   logic [2:0]  off;
   assign sel  = AD[15:3] == BASE[15:3];
   assign wr   = sel & RDY & WE;
   assign rd   = sel & RDY & ~WE;
   assign off  = AD[2:0];
   assign tick = ctrl_q[0] & (pre_q == PRE_MAX);
   assign uf   = tick & (cnt_q == 16'd0);
   assign DI   = di_q;
   assign IRQ  = irq_q;
   always_comb begin
      pre_d  = (!ctrl_q[0] || tick) ? 8'd0 : pre_q + 8'd1;
      cnt_d  = !tick ? cnt_q : (cnt_q != 16'd0) ? cnt_q - 16'd1 : ctrl_q[1] ? lat_q : 16'hFFFF;
      lat_d  = lat_q;
      ctrl_d = ctrl_q;
      if_d   = if_q | uf;
      scr_d  = scr_q;
      snap_d = (rd && off == 3'd0) ? cnt_q[15:8] : snap_q;
      // one-shot stops itself; a CTRL write below overrides this
      if (uf && !ctrl_q[1])
         ctrl_d[0] = 1'b0;
      // bus writes are applied last so they win over timer events,
      // except a STAT clear, which loses to a simultaneous underflow
      if (wr)
         case (off)
            3'd0, 3'd2: lat_d[7:0] = DO;
            3'd1: begin
               lat_d[15:8] = DO;
               cnt_d       = {DO, lat_q[7:0]};
               if_d        = 1'b0;
               pre_d       = 8'd0;
            end
            3'd3: lat_d[15:8] = DO;
            3'd4: ctrl_d = DO[2:0];
            3'd5: if_d = DO[0] ? uf : if_q | uf;
            3'd6: scr_d = DO;
            default: ;
         endcase
      case (off)
         3'd0:    rdata = cnt_q[7:0];
         3'd1:    rdata = snap_q;
         3'd2:    rdata = lat_q[7:0];
         3'd3:    rdata = lat_q[15:8];
         3'd4:    rdata = {5'd0, ctrl_q};
         3'd5:    rdata = {7'd0, if_q};
         3'd6:    rdata = scr_q;
         default: rdata = 8'd0;
      endcase
      di_d  = rd ? rdata : 8'd0;
      irq_d = if_q & ctrl_q[2];
   end
   always_ff @(posedge clk) begin
      if (RST) begin
         cnt_q  <= 16'hFFFF;
         lat_q  <= 16'hFFFF;
         snap_q <= 8'd0;
         ctrl_q <= 3'd0;
         if_q   <= 1'b0;
         scr_q  <= 8'd0;
         pre_q  <= 8'd0;
         di_q   <= 8'd0;
         irq_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lat_q  <= lat_d;
         snap_q <= snap_d;
         ctrl_q <= ctrl_d;
         if_q   <= if_d;
         scr_q  <= scr_d;
         pre_q  <= pre_d;
         di_q   <= di_d;
         irq_q  <= irq_d;
      end
   end
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed self-checking bench for bus_timer (BASE=FE00, PRESCALE=1).
module tb_bus_timer;
   logic        clk = 1'b0;
   logic        RST;
   logic [15:0] AD;
   logic [7:0]  DO;
   logic        WE;
   logic        RDY;
   logic [7:0]  DI;
   logic        IRQ;
   int          tests = 0;
   int          fails = 0;
   bus_timer #(.BASE(16'hFE00), .PRESCALE(1)) dut (
      .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .RDY(RDY), .DI(DI), .IRQ(IRQ)
   );
   always #5 clk = ~clk;
   // one bus cycle starting at a negedge; returns DI sampled at the following negedge
   task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d, input logic r, output logic [7:0] q);
      AD = a; WE = w; DO = d; RDY = r;
      @(negedge clk);
      q = DI;
      AD = 16'h0000; WE = 1'b0; DO = 8'h00; RDY = 1'b1;
   endtask
   task automatic wr(input logic [2:0] o, input logic [7:0] d);
      logic [7:0] q;
      bus(16'hFE00 + 16'(o), 1'b1, d, 1'b1, q);
   endtask
   task automatic rd(input logic [2:0] o, output logic [7:0] q);
      bus(16'hFE00 + 16'(o), 1'b0, 8'h00, 1'b1, q);
   endtask
   task automatic chk_irq(input string name, input logic exp);
      tests++;
      if (IRQ !== exp) begin
         fails++;
         $display("FAIL %s: IRQ=%b expected %b", name, IRQ, exp);
      end
   endtask
   task automatic chk_rd(input string name, input logic [2:0] o, input logic [7:0] exp);
      logic [7:0] q;
      rd(o, q);
      tests++;
      if (q !== exp) begin
         fails++;
         $display("FAIL %s: DI=%02h expected %02h", name, q, exp);
      end
   endtask
   task automatic test_reset;
      logic [7:0] e [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      RST = 1'b1; AD = 16'h0000; DO = 8'h00; WE = 1'b0; RDY = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (DI !== 8'h00 || IRQ !== 1'b0) begin
         fails++;
         $display("FAIL reset_out: DI=%02h IRQ=%b expected 00 0", DI, IRQ);
      end
      RST = 1'b0;
      chk_rd("reset_snap", 3'd1, 8'h00);
      for (int i = 0; i < 8; i++) chk_rd($sformatf("reset_off%0d", i), 3'(i), e[i]);
   endtask
   task automatic test_periodic;
      wr(3'd2, 8'h03);
      wr(3'd1, 8'h00);
      wr(3'd4, 8'h07);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk_irq($sformatf("periodic_c%0d", k), k == 5);
      end
      wr(3'd5, 8'h01);
      chk_irq("periodic_clr_c6", 1'b1);
      @(negedge clk); chk_irq("periodic_clr_c7", 1'b0);
      @(negedge clk); chk_irq("periodic_c8", 1'b0);
      @(negedge clk); chk_irq("periodic_c9", 1'b1);
      wr(3'd5, 8'h01);
      wr(3'd4, 8'h00);
   endtask
   task automatic test_oneshot;
      wr(3'd2, 8'h02);
      wr(3'd3, 8'h00);
      wr(3'd1, 8'h00);
      wr(3'd4, 8'h05);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk_irq($sformatf("oneshot_c%0d", k), k == 4);
      end
      chk_rd("oneshot_ctrl", 3'd4, 8'h04);
      chk_rd("oneshot_cnt_lo", 3'd0, 8'hFF);
      chk_rd("oneshot_cnt_hi", 3'd1, 8'hFF);
      wr(3'd5, 8'h01);
      repeat (8) @(negedge clk);
      chk_irq("oneshot_no_repeat", 1'b0);
      chk_rd("oneshot_stat", 3'd5, 8'h00);
   endtask
   task automatic test_rdy;
      logic [7:0] q;
      wr(3'd1, 8'h12);
      bus(16'hFE04, 1'b1, 8'h06, 1'b0, q);
      tests++;
      if (q !== 8'h00) begin fails++; $display("FAIL rdy_wr_di: DI=%02h expected 00", q); end
      bus(16'hFE00, 1'b0, 8'h00, 1'b0, q);
      tests++;
      if (q !== 8'h00) begin fails++; $display("FAIL rdy_rd_di: DI=%02h expected 00", q); end
      chk_rd("rdy_ctrl_kept", 3'd4, 8'h04);
      chk_rd("rdy_snap_kept", 3'd1, 8'hFF);
      chk_rd("rdy_cnt_lo", 3'd0, 8'h02);
      chk_rd("rdy_snap_new", 3'd1, 8'h12);
      wr(3'd4, 8'h06);
      chk_rd("rdy_ctrl_commit", 3'd4, 8'h06);
      bus(16'hFE06, 1'b1, 8'h5A, 1'b1, q);
      tests++;
      if (q !== 8'h00) begin fails++; $display("FAIL write_di_zero: DI=%02h expected 00", q); end
      chk_rd("scratch", 3'd6, 8'h5A);
   endtask
   task automatic test_collisions;
      wr(3'd3, 8'h00);
      wr(3'd2, 8'h02);
      wr(3'd1, 8'h00);
      wr(3'd4, 8'h03);
      @(negedge clk);
      @(negedge clk);
      wr(3'd5, 8'h01);
      chk_rd("stat_clr_vs_uf", 3'd5, 8'h01);
      @(negedge clk);
      wr(3'd1, 8'h05);
      chk_rd("cnthi_vs_uf_if", 3'd5, 8'h00);
      wr(3'd4, 8'h00);
      chk_rd("cnthi_vs_uf_lo", 3'd0, 8'h00);
      chk_rd("cnthi_vs_uf_hi", 3'd1, 8'h05);
   endtask
   task automatic test_decode_and_reset;
      logic [7:0] q;
      logic [7:0] e [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
      bus(16'hFE0E, 1'b1, 8'hAA, 1'b1, q);
      bus(16'hFDFE, 1'b1, 8'hAA, 1'b1, q);
      bus(16'hFE0C, 1'b1, 8'h07, 1'b1, q);
      bus(16'hFE08, 1'b0, 8'h00, 1'b1, q);
      tests++;
      if (q !== 8'h00) begin fails++; $display("FAIL decode_above: DI=%02h expected 00", q); end
      bus(16'hFDFF, 1'b0, 8'h00, 1'b1, q);
      tests++;
      if (q !== 8'h00) begin fails++; $display("FAIL decode_below: DI=%02h expected 00", q); end
      chk_rd("decode_scratch_kept", 3'd6, 8'h5A);
      chk_rd("decode_ctrl_kept", 3'd4, 8'h00);
      wr(3'd3, 8'h00);
      wr(3'd2, 8'h01);
      wr(3'd1, 8'h00);
      wr(3'd4, 8'h07);
      repeat (3) @(negedge clk);
      chk_irq("pre_reset_irq", 1'b1);
      RST = 1'b1; AD = 16'hFE06; WE = 1'b0;
      @(negedge clk);
      tests++;
      if (DI !== 8'h00 || IRQ !== 1'b0) begin
         fails++;
         $display("FAIL midreset_out: DI=%02h IRQ=%b expected 00 0", DI, IRQ);
      end
      RST = 1'b0; AD = 16'h0000;
      chk_rd("midreset_snap", 3'd1, 8'h00);
      for (int i = 0; i < 6; i++) chk_rd($sformatf("midreset_off%0d", i == 0 ? 0 : i + 1), i == 0 ? 3'd0 : 3'(i + 1), e[i]);
      repeat (4) @(negedge clk);
      chk_irq("midreset_irq_idle", 1'b0);
   endtask
   initial begin
      test_reset;
      test_periodic;
      test_oneshot;
      test_rdy;
      test_collisions;
      test_decode_and_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
